// File: rtl/register_dumper.sv
// Walks every architectural register through a spare combinational read port and
// streams them as a framed byte sequence: header, 4 bytes per register MSB first, checksum.
module register_dumper #(
    parameter int          NUM_REGS    = 32,
    parameter int          ADDR_WIDTH  = 5,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [31:0]           rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    // Byte handshake: a byte moves on every rising clock edge where tx_valid && tx_ready;
    // once tx_valid is raised, it and tx_data hold unchanged until that edge (reset excepted).

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        ADDR   = 3'd2,
        LOAD   = 3'd3,
        SEND   = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   index;
    logic [31:0]             shift;
    logic [7:0]              checksum;
    logic [1:0]              byte_cnt;
    logic                    accept;

    assign accept    = tx_valid && tx_ready;
    assign rd_addr   = index;
    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs decode from the state register only, so reset drops tx_valid without waiting for a clock.
    always_comb begin
        next_state = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = HEADER;
            end
            HEADER: begin
                tx_valid = 1'b1;
                tx_data  = HEADER_BYTE;
                if (tx_ready) next_state = ADDR;
            end
            ADDR: begin
                next_state = LOAD;
            end
            LOAD: begin
                next_state = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift[31:24];
                if (tx_ready && byte_cnt == 2'd3) begin
                    next_state = (index == LAST_IDX) ? CSUM : ADDR;
                end
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = checksum;
                if (tx_ready) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            index    <= '0;
            shift    <= '0;
            checksum <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        index    <= '0;
                        checksum <= '0;
                    end
                end
                LOAD: begin
                    shift    <= rd_data;
                    byte_cnt <= '0;
                end
                SEND: begin
                    if (accept) begin
                        checksum <= checksum + shift[31:24];
                        shift    <= {shift[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                        // Index stops at the last register; CSUM follows instead of a wrap.
                        if (byte_cnt == 2'd3 && index != LAST_IDX) begin
                            index <= index + 1'b1;
                        end
                    end
                end
                DONE: begin
                    index <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_dumper.sv
// Bench for register_dumper: scenario table plus random register images, checked
// against a frame model built directly from the frame format rules.
module tb_register_dumper;

    localparam int NUM_REGS = 32;
    localparam int AW       = 5;
    localparam int FRAME_LEN = 2 + 4 * NUM_REGS;
    // HEADER + per register (ADDR + LOAD + 4 SEND) + CSUM + DONE, with tx_ready always high
    localparam int BUSY_CYCLES = 1 + NUM_REGS * 6 + 1 + 1;
    localparam int LIMIT = 5000;

    // ---------------- clock / reset ----------------
    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;
    logic [2:0]    dbg_state;

    always #5 clock = ~clock;

    logic [31:0] regs [NUM_REGS];
    assign rd_data = regs[rd_addr];

    register_dumper #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(AW), .HEADER_BYTE(8'hA5)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [31:0] snap [NUM_REGS];

    int done_cnt, busy_cnt, done_at, stab_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame model: header, each register's 4 bytes MSB first, then sum of data bytes mod 256.
    task automatic build_frame();
        int sum;
        sum = 0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(8'((snap[r] >> (8 * b)) & 32'hFF));
                sum += int'((snap[r] >> (8 * b)) & 32'hFF);
            end
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    task automatic take_snapshot();
        for (int r = 0; r < NUM_REGS; r++) snap[r] = regs[r];
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({tag, $sformatf("_byte%0d", i)}, 64'(got_q[i]), 64'(exp_q[i]));
        end
    endtask

    // ---------------- driver ----------------
    // Runs one dump from a start pulse. Inputs change at negedges; outputs are sampled
    // at the same negedge, i.e. just before the posedge that acts on them.
    task automatic run_dump(input int pct, input int restart_at, input bit live, input int abort_at);
        bit prev_hold, restarted, wrote, finished;
        logic [7:0] prev_data;
        got_q.delete();
        done_cnt = 0; busy_cnt = 0; done_at = -1; stab_err = 0;
        prev_hold = 0; prev_data = 8'h00; restarted = 0; wrote = 0; finished = 0;
        for (int cyc = 0; cyc < LIMIT; cyc++) begin
            start = (cyc == 0);
            if (restart_at >= 0 && !restarted && got_q.size() == restart_at) begin
                start = 1'b1;
                restarted = 1;
            end
            if (live && !wrote && got_q.size() == 15) begin
                regs[10] = 32'hCAFEF00D;
                regs[2]  = 32'h00000001;
                wrote = 1;
            end
            tx_ready = ($urandom_range(99) < pct);
            if (prev_hold && (!tx_valid || tx_data !== prev_data)) stab_err++;
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            @(negedge clock);
            if (abort_at >= 0 && got_q.size() == abort_at) begin
                finished = 1;
                break;
            end
            if (done_cnt > 0) begin
                finished = 1;
                break;
            end
        end
        start = 1'b0;
        check("dump_finished_in_budget", 64'(finished), 64'd1);
    endtask

    task automatic set_regs(input logic [31:0] x1, input logic [31:0] x31);
        for (int r = 0; r < NUM_REGS; r++) regs[r] = 32'h0;
        regs[1]  = x1;
        regs[31] = x31;
    endtask

    typedef struct {
        int          pct;
        int          restart_at;
        bit          live;
        logic [31:0] x1;
        logic [31:0] x31;
        logic [7:0]  exp_csum;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{100, -1, 1'b0, 32'h12345678, 32'hDEADBEEF, 8'h4C};
        vecs[1] = '{30,  -1, 1'b0, 32'h12345678, 32'hDEADBEEF, 8'h4C};
        vecs[2] = '{100, 50, 1'b0, 32'h12345678, 32'hDEADBEEF, 8'h4C};
        vecs[3] = '{100, -1, 1'b1, 32'h12345678, 32'hDEADBEEF, 8'h11};
        vecs[4] = '{100, -1, 1'b0, 32'hFFFFFFFF, 32'h01010101, 8'h00};

        reset_n = 1'b0; start = 1'b0; tx_ready = 1'b0;
        set_regs(32'h0, 32'h0);
        repeat (3) @(negedge clock);
        check("in_reset_tx_valid", 64'(tx_valid), 64'd0);
        check("in_reset_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("idle_outputs", {tx_valid, busy, done, 3'(rd_addr)}, 64'd0);
        end

        // ---------------- scenario table ----------------
        for (int v = 0; v < 5; v++) begin
            set_regs(vecs[v].x1, vecs[v].x31);
            take_snapshot();
            if (vecs[v].live) snap[10] = 32'hCAFEF00D;
            build_frame();
            run_dump(vecs[v].pct, vecs[v].restart_at, vecs[v].live, -1);
            compare_frame($sformatf("vec%0d", v));
            if (got_q.size() > 0) check($sformatf("vec%0d_csum", v), 64'(got_q[got_q.size()-1]), 64'(vecs[v].exp_csum));
            check($sformatf("vec%0d_done_pulses", v), 64'(done_cnt), 64'd1);
            check($sformatf("vec%0d_handshake_stable", v), 64'(stab_err), 64'd0);
            if (vecs[v].pct == 100) begin
                check($sformatf("vec%0d_busy_cycles", v), 64'(busy_cnt), 64'(BUSY_CYCLES));
                check($sformatf("vec%0d_done_cycle", v), 64'(done_at), 64'(BUSY_CYCLES));
            end
            @(negedge clock);
            check($sformatf("vec%0d_idle_after", v), {busy, done, tx_valid}, 64'd0);
        end

        // ---------------- reset during SEND of x5 ----------------
        set_regs(32'h12345678, 32'hDEADBEEF);
        regs[5] = 32'h55AA55AA;
        run_dump(100, -1, 1'b0, 23);
        check("pre_reset_tx_valid", 64'(tx_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("reset_drops_tx_valid", 64'(tx_valid), 64'd0);
        check("reset_drops_busy", 64'(busy), 64'd0);
        check("reset_rd_addr", 64'(rd_addr), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        take_snapshot();
        build_frame();
        run_dump(100, -1, 1'b0, -1);
        compare_frame("after_reset");
        if (got_q.size() > 0) check("after_reset_header", 64'(got_q[0]), 64'hA5);
        check("after_reset_done_pulses", 64'(done_cnt), 64'd1);

        // ---------------- random register images ----------------
        for (int t = 0; t < 3; t++) begin
            regs[0] = 32'h0;
            for (int r = 1; r < NUM_REGS; r++) regs[r] = $urandom;
            take_snapshot();
            build_frame();
            run_dump(int'($urandom_range(100, 20)), -1, 1'b0, -1);
            compare_frame($sformatf("rand%0d", t));
            check($sformatf("rand%0d_handshake_stable", t), 64'(stab_err), 64'd0);
            check($sformatf("rand%0d_done_pulses", t), 64'(done_cnt), 64'd1);
            @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
